// File: rtl/inet_stack_pkg.sv
// Protocol constants and the IPv4 header checksum helper shared by the inet Tx/Rx stack.
package inet_stack_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
  localparam int          HDR_WORDS      = 11;

  // Nine non-zero halfwords of a 20-byte IPv4 header; 20 bits hold the sum without loss.
  function automatic logic [15:0] ip_hdr_csum(input logic [15:0] total_len,
                                              input logic [15:0] id,
                                              input logic [7:0]  ttl,
                                              input logic [31:0] src_ip,
                                              input logic [31:0] dst_ip);
    logic [19:0] acc;
    logic [16:0] fold1;
    logic [16:0] fold2;
    acc = 20'({IP_VER_IHL, 8'h00}) + 20'(total_len) + 20'(id) + 20'(IP_FLAGS_DF)
        + 20'({ttl, IP_PROTO_UDP}) + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
        + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
    fold1 = 17'(acc[15:0]) + 17'(acc[19:16]);
    fold2 = 17'(fold1[15:0]) + 17'(fold1[16]);
    return ~fold2[15:0];
  endfunction

endpackage

// File: rtl/udp_tx_hdr_insert.sv
// Prepends pad + Ethernet + IPv4 + UDP headers (11 words) to a 32-bit Avalon-ST payload.
// Optional UDP_TX_LEN_CHECK_EN: payload length checking against the descriptor with truncation.
module udp_tx_hdr_insert
  import inet_stack_pkg::*;
#(
  parameter logic [7:0]  TTL     = 8'd64,
  parameter logic [15:0] ID_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] cfg_src_mac,
  input  logic [47:0] cfg_dst_mac,
  input  logic [31:0] cfg_src_ip,
  input  logic [31:0] cfg_dst_ip,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dst_port,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [15:0] desc_len,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_empty,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [1:0]  out_empty,
  output logic [1:0]  out_error
);

  // Handshakes: a beat moves on a cycle where valid && ready, ready latency 0.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CSUM    = 3'd1;
  localparam logic [2:0] ST_HDR     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
`ifdef UDP_TX_LEN_CHECK_EN
  localparam logic [2:0] ST_DROP    = 3'd4;
`endif

  logic [2:0]  state_q,  state_d;
  logic [47:0] dmac_q,   dmac_d;
  logic [47:0] smac_q,   smac_d;
  logic [31:0] sip_q,    sip_d;
  logic [31:0] dip_q,    dip_d;
  logic [15:0] sport_q,  sport_d;
  logic [15:0] dport_q,  dport_d;
  logic [15:0] len_q,    len_d;
  logic [15:0] ip_id_q,  ip_id_d;
  logic [15:0] csum_q,   csum_d;
  logic [3:0]  widx_q,   widx_d;
  logic [31:0] hdr_word;
  logic        last_hdr;
  logic        unused_in_sop;
`ifdef UDP_TX_LEN_CHECK_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] beat_total;
`endif

  // Start-of-packet on the input carries no information: the header defines the frame start.
  assign unused_in_sop = in_sop;
  assign last_hdr      = (widx_q == 4'(HDR_WORDS - 1));

  always_comb begin
    hdr_word = '0;
    case (widx_q)
      4'd0:    hdr_word = {16'h0000, dmac_q[47:32]};
      4'd1:    hdr_word = dmac_q[31:0];
      4'd2:    hdr_word = smac_q[47:16];
      4'd3:    hdr_word = {smac_q[15:0], ETHERTYPE_IPV4};
      4'd4:    hdr_word = {IP_VER_IHL, 8'h00, len_q + 16'd28};
      4'd5:    hdr_word = {ip_id_q, IP_FLAGS_DF};
      4'd6:    hdr_word = {TTL, IP_PROTO_UDP, csum_q};
      4'd7:    hdr_word = sip_q;
      4'd8:    hdr_word = dip_q;
      4'd9:    hdr_word = {sport_q, dport_q};
      default: hdr_word = {len_q + 16'd8, 16'h0000};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dmac_d     = dmac_q;
    smac_d     = smac_q;
    sip_d      = sip_q;
    dip_d      = dip_q;
    sport_d    = sport_q;
    dport_d    = dport_q;
    len_d      = len_q;
    ip_id_d    = ip_id_q;
    csum_d     = csum_q;
    widx_d     = widx_q;
    desc_ready = 1'b0;
    in_ready   = 1'b0;
    out_data   = '0;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_empty  = 2'b00;
    out_error  = 2'b00;
`ifdef UDP_TX_LEN_CHECK_EN
    byte_cnt_d = byte_cnt_q;
    beat_total = byte_cnt_q + (in_eop ? 16'(3'd4 - {1'b0, in_empty}) : 16'd4);
`endif
    case (state_q)
      ST_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          dmac_d  = cfg_dst_mac;
          smac_d  = cfg_src_mac;
          sip_d   = cfg_src_ip;
          dip_d   = cfg_dst_ip;
          sport_d = cfg_src_port;
          dport_d = cfg_dst_port;
          len_d   = desc_len;
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        csum_d  = ip_hdr_csum(len_q + 16'd28, ip_id_q, TTL, sip_q, dip_q);
        widx_d  = 4'd0;
        state_d = ST_HDR;
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_word;
        out_sop   = (widx_q == 4'd0);
        out_eop   = last_hdr && (len_q == 16'd0);
        if (out_ready) begin
          if (!last_hdr) begin
            widx_d = widx_q + 4'd1;
          end else if (len_q == 16'd0) begin
            ip_id_d = ip_id_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
`ifdef UDP_TX_LEN_CHECK_EN
            byte_cnt_d = 16'd0;
`endif
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        out_data  = in_data;
        out_valid = in_valid;
        in_ready  = out_ready;
        out_eop   = in_eop;
        out_empty = in_empty;
`ifdef UDP_TX_LEN_CHECK_EN
        // A non-eop beat that already reaches the descriptor length leaves no room for more
        // payload, so the frame is closed on it and the rest of the input is discarded.
        if (in_valid && in_eop) begin
          out_error[0] = (beat_total != len_q);
        end else if (in_valid && (beat_total >= len_q)) begin
          out_eop   = 1'b1;
          out_error = 2'b10;
        end
        if (in_valid && out_ready) begin
          byte_cnt_d = beat_total;
          if (in_eop) begin
            ip_id_d = ip_id_q + 16'd1;
            state_d = ST_IDLE;
          end else if (beat_total >= len_q) begin
            ip_id_d = ip_id_q + 16'd1;
            state_d = ST_DROP;
          end
        end
`else
        if (in_valid && out_ready && in_eop) begin
          ip_id_d = ip_id_q + 16'd1;
          state_d = ST_IDLE;
        end
`endif
      end
`ifdef UDP_TX_LEN_CHECK_EN
      ST_DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_eop) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dmac_q     <= '0;
      smac_q     <= '0;
      sip_q      <= '0;
      dip_q      <= '0;
      sport_q    <= '0;
      dport_q    <= '0;
      len_q      <= '0;
      ip_id_q    <= ID_INIT;
      csum_q     <= '0;
      widx_q     <= '0;
`ifdef UDP_TX_LEN_CHECK_EN
      byte_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dmac_q     <= dmac_d;
      smac_q     <= smac_d;
      sip_q      <= sip_d;
      dip_q      <= dip_d;
      sport_q    <= sport_d;
      dport_q    <= dport_d;
      len_q      <= len_d;
      ip_id_q    <= ip_id_d;
      csum_q     <= csum_d;
      widx_q     <= widx_d;
`ifdef UDP_TX_LEN_CHECK_EN
      byte_cnt_q <= byte_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_udp_tx_hdr_insert.sv
// Directed bench for udp_tx_hdr_insert: two instances (TTL=1/ID b9a3 and TTL=64/ID ffff)
// share all inputs; captured output beats are checked against hand values and a header model.
module tb_udp_tx_hdr_insert;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [47:0] cfg_src_mac, cfg_dst_mac;
  logic [31:0] cfg_src_ip, cfg_dst_ip;
  logic [15:0] cfg_src_port, cfg_dst_port;
  logic        desc_valid;
  logic [15:0] desc_len;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop;
  logic [1:0]  in_empty;
  logic        out_ready;

  logic        desc_ready_a, in_ready_a, out_valid_a, out_sop_a, out_eop_a;
  logic [31:0] out_data_a;
  logic [1:0]  out_empty_a, out_error_a;
  logic        desc_ready_b, in_ready_b, out_valid_b, out_sop_b, out_eop_b;
  logic [31:0] out_data_b;
  logic [1:0]  out_empty_b, out_error_b;

  udp_tx_hdr_insert #(.TTL(8'd1), .ID_INIT(16'hb9a3)) dut_a (
    .clk(clk), .reset(reset),
    .cfg_src_mac(cfg_src_mac), .cfg_dst_mac(cfg_dst_mac),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
    .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
    .desc_valid(desc_valid), .desc_ready(desc_ready_a), .desc_len(desc_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sop(out_sop_a), .out_eop(out_eop_a), .out_empty(out_empty_a), .out_error(out_error_a)
  );

  udp_tx_hdr_insert #(.TTL(8'd64), .ID_INIT(16'hffff)) dut_b (
    .clk(clk), .reset(reset),
    .cfg_src_mac(cfg_src_mac), .cfg_dst_mac(cfg_dst_mac),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
    .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
    .desc_valid(desc_valid), .desc_ready(desc_ready_b), .desc_len(desc_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sop(out_sop_b), .out_eop(out_eop_b), .out_empty(out_empty_b), .out_error(out_error_b)
  );

  // ---------------- scoreboard ----------------
  // Beat layout: {sop, eop, empty[1:0], error[1:0], data[31:0]}
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [37:0] exp_q[$];
  logic [37:0] got_q[$];
  logic [37:0] got_b_q[$];
  logic [15:0] id_a, id_b;

  always @(negedge clk) begin
    if (!reset && out_valid_a && out_ready)
      got_q.push_back({out_sop_a, out_eop_a, out_empty_a, out_error_a, out_data_a});
    if (!reset && out_valid_b && out_ready)
      got_b_q.push_back({out_sop_b, out_eop_b, out_empty_b, out_error_b, out_data_b});
  end

  function automatic logic [37:0] beat(input logic sop, input logic eop, input logic [1:0] empty,
                                       input logic [1:0] err, input logic [31:0] data);
    return {sop, eop, empty, err, data};
  endfunction

  function automatic logic [15:0] ref_csum(input logic [15:0] len, input logic [15:0] id,
                                           input logic [7:0] ttl);
    logic [15:0] hw [10];
    logic [31:0] s;
    hw[0] = 16'h4500;            hw[1] = len + 16'd28;       hw[2] = id;
    hw[3] = 16'h4000;            hw[4] = {ttl, 8'h11};       hw[5] = 16'h0000;
    hw[6] = cfg_src_ip[31:16];   hw[7] = cfg_src_ip[15:0];
    hw[8] = cfg_dst_ip[31:16];   hw[9] = cfg_dst_ip[15:0];
    s = 32'd0;
    for (int i = 0; i < 10; i++) s = s + {16'h0000, hw[i]};
    while (s[31:16] != 16'h0000) s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    return ~s[15:0];
  endfunction

  function automatic logic [31:0] ref_word(input int i, input logic [15:0] len,
                                           input logic [15:0] id, input logic [7:0] ttl);
    case (i)
      0:       return {16'h0000, cfg_dst_mac[47:32]};
      1:       return cfg_dst_mac[31:0];
      2:       return cfg_src_mac[47:16];
      3:       return {cfg_src_mac[15:0], 16'h0800};
      4:       return {16'h4500, len + 16'd28};
      5:       return {id, 16'h4000};
      6:       return {ttl, 8'h11, ref_csum(len, id, ttl)};
      7:       return cfg_src_ip;
      8:       return cfg_dst_ip;
      9:       return {cfg_src_port, cfg_dst_port};
      default: return {len + 16'd8, 16'h0000};
    endcase
  endfunction

  task automatic push_hdr(input logic [15:0] len, input logic [15:0] id, input logic [7:0] ttl);
    for (int i = 0; i < 11; i++)
      exp_q.push_back(beat(i == 0, (i == 10) && (len == 16'd0), 2'd0, 2'd0, ref_word(i, len, id, ttl)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg_default();
    cfg_dst_mac  = 48'h01005e010101;
    cfg_src_mac  = 48'h5453edb52daa;
    cfg_src_ip   = 32'hc0a80a02;
    cfg_dst_ip   = 32'hef010101;
    cfg_src_port = 16'hbe98;
    cfg_dst_port = 16'h2382;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    id_a = 16'hb9a3;
    id_b = 16'hffff;
    got_q.delete();
    got_b_q.delete();
    exp_q.delete();
  endtask

  task automatic start_frame(input logic [15:0] len);
    bit ok = 0;
    desc_len   = len;
    desc_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (desc_ready_a) ok = 1;
    end
    @(posedge clk);
    #1 desc_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL desc_accept_timeout: desc_ready never seen, required 1");
    end
  endtask

  task automatic send_beats(input int n, input logic [1:0] last_empty, input logic last_eop,
                            input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      bit ok = 0;
      in_data  = base + 32'(k);
      in_sop   = (k == 0);
      in_eop   = last_eop && (k == n - 1);
      in_empty = (k == n - 1) ? last_empty : 2'd0;
      in_valid = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        if (in_ready_a) ok = 1;
      end
      @(posedge clk);
      #1;
      if (!ok) begin
        n_cmp++; n_fail++;
        $display("FAIL in_ready_timeout: beat %0d never accepted, required accept", k);
      end
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 2'd0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (desc_ready_a) ok = 1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: desc_ready stayed 0, required 1");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (desc_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_desc_ready: got %b want 1", desc_ready_a); end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid_a); end
    n_cmp++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready_a); end
    n_cmp++; if (out_data_a !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data_a); end
    n_cmp++; if ({out_sop_a, out_eop_a, out_empty_a, out_error_a} !== 6'b0)
      begin n_fail++; $display("FAIL rst_out_flags: got %b want 000000", {out_sop_a, out_eop_a, out_empty_a, out_error_a}); end
    do_reset();
  endtask

  task automatic test_basic();
    set_cfg_default();
    got_q.delete(); exp_q.delete();
    start_frame(16'd6);
    @(negedge clk);
    n_cmp++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL lat_csum_valid: got %b want 0", out_valid_a); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({out_valid_a, out_sop_a} !== 2'b11) begin n_fail++; $display("FAIL lat_first_valid: got %b want 11", {out_valid_a, out_sop_a}); end
    exp_q.push_back(beat(1, 0, 0, 0, 32'h00000100));
    exp_q.push_back(beat(0, 0, 0, 0, 32'h5e010101));
    exp_q.push_back(beat(0, 0, 0, 0, 32'h5453edb5));
    exp_q.push_back(beat(0, 0, 0, 0, 32'h2daa0800));
    exp_q.push_back(beat(0, 0, 0, 0, 32'h45000022));
    exp_q.push_back(beat(0, 0, 0, 0, 32'hb9a34000));
    exp_q.push_back(beat(0, 0, 0, 0, 32'h0111057b));
    exp_q.push_back(beat(0, 0, 0, 0, 32'hc0a80a02));
    exp_q.push_back(beat(0, 0, 0, 0, 32'hef010101));
    exp_q.push_back(beat(0, 0, 0, 0, 32'hbe982382));
    exp_q.push_back(beat(0, 0, 0, 0, 32'h000e0000));
    exp_q.push_back(beat(0, 0, 0, 0, 32'h11223344));
    exp_q.push_back(beat(0, 1, 2, 0, 32'h11223345));
    send_beats(2, 2'd2, 1'b1, 32'h11223344);
    wait_idle();
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    id_a++; id_b++;
  endtask

  task automatic test_stall();
    logic [31:0] held;
    bit held_v = 0;
    int sops = 0;
    set_cfg_default();
    cfg_src_port = 16'h1234;
    got_q.delete(); exp_q.delete();
    push_hdr(16'd4, id_a, 8'd1);
    exp_q.push_back(beat(0, 1, 0, 0, 32'hcafe0000));
    start_frame(16'd4);
    for (int c = 0; c < 80 && got_q.size() < 11; c++) begin
      @(negedge clk);
      if (held_v) begin
        n_cmp++; if (out_data_a !== held) begin n_fail++; $display("FAIL stall_hold: got %h want %h", out_data_a, held); end
      end
      held_v = out_valid_a && !out_ready;
      held   = out_data_a;
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    send_beats(1, 2'd0, 1'b1, 32'hcafe0000);
    wait_idle();
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      if (got_q[i][37]) sops++;
    end
    n_cmp++; if (sops !== 1) begin n_fail++; $display("FAIL stall_sop_count: got %0d want 1", sops); end
    id_a++; id_b++;
  endtask

  task automatic test_zero_len();
    int pulses = 0;
    set_cfg_default();
    for (int f = 0; f < 2; f++) begin
      got_q.delete(); exp_q.delete();
      push_hdr(16'd0, id_a, 8'd1);
      start_frame(16'd0);
      for (int c = 0; c < 40 && got_q.size() < 11; c++) begin
        @(negedge clk);
        if (in_ready_a) pulses++;
        @(posedge clk); #1;
      end
      wait_idle();
      n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL zlen_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zlen_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      id_a++; id_b++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL zlen_in_ready: got %0d pulses want 0", pulses); end
    n_cmp++; if (got_q.size() < 6 || got_q[5][31:0] !== 32'hb9a64000)
      begin n_fail++; $display("FAIL zlen_id_inc: got %h want b9a64000", (got_q.size() > 5) ? got_q[5][31:0] : 32'hx); end
  endtask

  task automatic test_id_wrap();
    do_reset();
    set_cfg_default();
    for (int f = 0; f < 2; f++) begin
      push_hdr(16'd2, id_b, 8'd64);
      exp_q.push_back(beat(0, 1, 2, 0, 32'h0a0b0000 + 32'(f)));
      start_frame(16'd2);
      send_beats(1, 2'd2, 1'b1, 32'h0a0b0000 + 32'(f));
      wait_idle();
      id_a++; id_b++;
    end
    n_cmp++; if (got_b_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", got_b_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_b_q.size(); i++) begin
      n_cmp++; if (got_b_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_beat%0d: got %h want %h", i, got_b_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_b_q.size() < 18 || got_b_q[5][31:16] !== 16'hffff || got_b_q[17][31:16] !== 16'h0000)
      begin n_fail++; $display("FAIL wrap_ids: got size %0d, want ids ffff then 0000", got_b_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    set_cfg_default();
    got_q.delete(); got_b_q.delete(); exp_q.delete();
    start_frame(16'd4);
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk); #1;
      if (got_q.size() == 5) ok = 1;
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_reach_w5: got %0d words want 5", got_q.size()); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", out_valid_a); end
    n_cmp++; if (desc_ready_a !== 1'b1) begin n_fail++; $display("FAIL rmid_desc_ready: got %b want 1", desc_ready_a); end
    @(posedge clk); #1 reset = 1'b0;
    id_a = 16'hb9a3; id_b = 16'hffff;
    got_q.delete(); got_b_q.delete(); exp_q.delete();
    push_hdr(16'd0, id_a, 8'd1);
    start_frame(16'd0);
    wait_idle();
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_q.size() < 6 || got_q[5][31:0] !== 32'hb9a34000)
      begin n_fail++; $display("FAIL rmid_id_init: got size %0d, want w5 b9a34000", got_q.size()); end
    id_a++; id_b++;
  endtask

`ifdef UDP_TX_LEN_CHECK_EN
  task automatic test_len_check();
    set_cfg_default();
    got_q.delete(); exp_q.delete();
    push_hdr(16'd8, id_a, 8'd1);
    exp_q.push_back(beat(0, 0, 0, 2'b00, 32'h77000000));
    exp_q.push_back(beat(0, 1, 0, 2'b10, 32'h77000001));
    start_frame(16'd8);
    send_beats(3, 2'd0, 1'b1, 32'h77000000);
    wait_idle();
    id_a++; id_b++;
    push_hdr(16'd8, id_a, 8'd1);
    exp_q.push_back(beat(0, 0, 0, 2'b00, 32'h88000000));
    exp_q.push_back(beat(0, 1, 1, 2'b01, 32'h88000001));
    start_frame(16'd8);
    send_beats(2, 2'd1, 1'b1, 32'h88000000);
    wait_idle();
    id_a++; id_b++;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL lchk_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lchk_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; desc_valid = 1'b0; desc_len = '0;
    in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 2'd0;
    out_ready = 1'b1;
    set_cfg_default();
    id_a = 16'hb9a3; id_b = 16'hffff;
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_id_wrap();
    test_reset_mid();
`ifdef UDP_TX_LEN_CHECK_EN
    test_len_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
